// File: rtl/aes_mixcol_seq.sv
// aes_mixcol_seq: AES (Inv)MixColumns over a 128-bit state using one shared mix-byte unit, 16 steps per state
module aes_mixcol_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [127:0] src_q, src_d, acc_q, acc_d, out_q, out_d, sh;
  logic inv_q, inv_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] col, rot;
  logic [63:0] dbl;
  logic [7:0] mb;
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 4; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // column c = cnt[3:2], rotated left by one byte per cnt[1:0]
  always_comb begin
    sh  = src_q << {cnt_q[3:2], 5'd0};
    col = sh[127:96];
    dbl = {col, col} >> (6'd32 - {1'b0, cnt_q[1:0], 3'd0});
    rot = dbl[31:0];
    mb  = inv_q ? gm(rot[31:24], 4'he) ^ gm(rot[23:16], 4'hb) ^ gm(rot[15:8], 4'hd) ^ gm(rot[7:0], 4'h9)
                : gm(rot[31:24], 4'h2) ^ gm(rot[23:16], 4'h3) ^ rot[15:8] ^ rot[7:0];
  end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        src_d   = state_in;
        inv_d   = inv;
        cnt_d   = 4'd0;
        state_d = CALC;
      end
      CALC: begin
        acc_d = {acc_q[119:0], mb};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          out_d   = acc_d;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= 4'd0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign state_out = out_q;
endmodule

// File: tb/tb_aes_mixcol_seq.sv
// tb_aes_mixcol_seq: directed-vector bench for aes_mixcol_seq with immediate-assertion checks
module tb_aes_mixcol_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, inv = 1'b0, out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] state_out;
  int tests = 0, fails = 0, lat;
  int acc_t[2];
  int acc_n, out_n;
  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] IMM_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] IMM_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  aes_mixcol_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
    .inv(inv), .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] s, input logic i);
    state_in = s;
    inv = i;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("accept_busy", {125'd0, busy, in_ready, out_valid}, 128'b100);
  endtask

  // lat counts the cycle index after acceptance in which out_valid is seen
  task automatic wait_out(input bit wiggle, output int l);
    l = 1;
    while (!out_valid && l < 40) begin
      if (wiggle) begin
        inv = ~inv;
        state_in = ~state_in;
      end
      step();
      l++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_flags", {125'd0, busy, in_ready, out_valid}, 128'b010);
  endtask

  initial begin
    step();
    step();
    chk("rst_flags", {125'd0, busy, in_ready, out_valid}, 128'b010);
    chk("rst_out", state_out, '0);
    rst = 1'b0;

    accept(FIPS_IN, 1'b0);
    wait_out(1'b0, lat);
    chk("fwd_latency", lat, 17);
    chk("fwd_result", state_out, FIPS_OUT);
    handshake();
    chk("retain_out", state_out, FIPS_OUT);

    accept(FIPS_OUT, 1'b1);
    wait_out(1'b0, lat);
    chk("inv_latency", lat, 17);
    chk("inv_result", state_out, FIPS_IN);

    for (int k = 0; k < 20; k++) begin
      in_valid = k[0];
      inv = k[1];
      state_in = {4{k[31:0] * 32'h9e3779b9}};
      step();
      chk("bp_flags", {125'd0, busy, in_ready, out_valid}, 128'b101);
      chk("bp_out", state_out, FIPS_IN);
    end
    state_in = IMM_IN;
    inv = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", {125'd0, busy, in_ready, out_valid}, 128'b010);
    step();
    in_valid = 1'b0;
    chk("bp_accept", {125'd0, busy, in_ready, out_valid}, 128'b100);
    wait_out(1'b1, lat);
    chk("imm_latency", lat, 17);
    chk("imm_result", state_out, IMM_OUT);
    handshake();

    accept(FIPS_IN, 1'b0);
    repeat (7) step();
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_flags", {125'd0, busy, in_ready, out_valid}, 128'b010);
    chk("midrst_out", state_out, '0);
    step();
    chk("midrst_idle", {125'd0, busy, in_ready, out_valid}, 128'b010);
    accept(FIPS_IN, 1'b0);
    wait_out(1'b0, lat);
    chk("after_rst_latency", lat, 17);
    chk("after_rst_result", state_out, FIPS_OUT);
    handshake();

    out_ready = 1'b1;
    in_valid = 1'b1;
    state_in = FIPS_IN;
    inv = 1'b0;
    acc_n = 0;
    out_n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        chk("b2b_result", state_out, out_n == 0 ? FIPS_OUT : FIPS_IN);
        out_n++;
      end
      if (in_ready && acc_n < 2) begin
        acc_t[acc_n] = cyc;
        acc_n++;
      end
      step();
      if (acc_n == 1) begin
        state_in = FIPS_OUT;
        inv = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", acc_n, 2);
    chk("b2b_interval", acc_t[1] - acc_t[0], 18);
    chk("b2b_outputs", out_n, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_mixcol_seq.md
# aes_mixcol_seq

Sequencer that computes the full AES MixColumns / InvMixColumns transform of a 128-bit state by time-sharing a single mix-byte datapath, the combinational unit that turns a 32-bit column plus an inverse select into one output byte. It latches a state, feeds the shared unit one rotated column per cycle for 16 cycles, assembles the result, and presents it with a valid/ready handshake. It sits between the AES round-control logic and the round-key adder in the coprocessor datapath. Area is traded for latency.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a state is presented on state_in.
- in_ready  output  1  block can accept a state.
- state_in  input  128  AES state. Column c occupies [127-32c : 96-32c]. Within a column, byte 0 is the MSB byte.
- inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on acceptance.
- out_valid  output  1  state_out holds a completed result.
- out_ready  input  1  consumer takes the result.
- state_out  output  128  transformed state, same layout as state_in.
- busy  output  1  high in CALC or DONE.

## Operation
- Shared datapath: one mix-byte instance.
  - Inputs are a 32-bit column and the latched inverse flag.
  - Output byte is 2·b0⊕3·b1⊕b2⊕b3 (forward) or e·b0⊕b·b1⊕d·b2⊕9·b3 (inverse), where b0 = column[31:24].
  - GF(2^8) uses reduction polynomial 0x11b.
- Registers:
  - src (128): latched input.
  - inv_r (1): latched inverse flag.
  - cnt (4): step counter.
  - acc (128): result shift register.
  - State register: IDLE, CALC or DONE.
- Step k (cnt = k, 0..15):
  - Column index c = cnt[3:2], byte index i = cnt[1:0].
  - The datapath receives src column c rotated left by 8·i bits. For example, i=1 gives {b1,b2,b3,b0}.
  - The output byte is shifted into acc from the LSB end: acc <= {acc[119:0], byte}. After 16 steps, the byte for column 0 / byte 0 sits in acc[127:120].
- State machine:
  - IDLE: in_ready=1. On in_valid: capture src<=state_in, inv_r<=inv, cnt<=0, then go to CALC.
  - CALC: perform step cnt and increment cnt. When the step with cnt=15 executes, copy the final acc into state_out and go to DONE. cnt wraps to 0.
  - DONE: out_valid=1 and state_out is held stable. On out_ready, go to IDLE.
- in_ready is low in CALC and DONE. in_valid in those states is ignored, and src and inv_r are not disturbed.
- inv and state_in changing after acceptance have no effect on the result in flight.
- state_out is a dedicated register. It retains the last result after the handshake completes and changes only at the CALC→DONE transition.

## Timing
- Reset values:
  - State IDLE, in_ready=1, out_valid=0, busy=0.
  - state_out=0, acc=0, src=0, inv_r=0, cnt=0.
- Acceptance cycle T: the rising edge at which in_valid && in_ready. CALC steps run in cycles T+1 … T+16.
- out_valid rises in cycle T+17, i.e. 17 cycles after acceptance.
  - If out_ready is already high in T+17, the handshake completes in that cycle. in_ready is then 1 in T+18.
- Minimum initiation interval: 18 cycles per state.
- out_ready held low: the block stays in DONE indefinitely with state_out and out_valid unchanged.
- out_ready high outside DONE: ignored.
- rst asserted in any state, including mid-CALC or in DONE: on the next edge, all registers take their reset values.
  - The partial result is discarded and is never presented.
  - rst has priority over in_valid in the same cycle. No acceptance occurs.
- Combinational paths:
  - Datapath input mux → mix-byte → acc only.
  - in_ready, out_valid and busy are decoded from the state register. They have no combinational dependence on in_valid or out_ready.

## Test plan
- Forward FIPS-197 vector:
  - Stimulus: inv=0, state_in=db135345_f20a225c_01010101_c6c6c6c6.
  - Required: state_out=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 17 cycles after acceptance.
- Inverse round trip:
  - Stimulus: inv=1, state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Required: state_out=db135345_f20a225c_01010101_c6c6c6c6.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid, toggling state_in, inv and in_valid.
  - Required: out_valid stays 1, state_out is constant, in_ready stays 0. Acceptance happens on the cycle after out_ready=1.
- Input-change immunity:
  - Stimulus: accept d4d4d4d5_2d26314c_00000000_ffffffff with inv=0, then flip inv and state_in every cycle during CALC.
  - Required: state_out=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle at step 7.
  - Required: next cycle has in_ready=1, out_valid=0, busy=0, state_out=0. A new forward vector then completes correctly.
- Back-to-back:
  - Stimulus: two states with out_ready tied high and in_valid tied high.
  - Required: acceptances 18 cycles apart, both results correct and each presented for one cycle.
